// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
package bit_serializer_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam logic        DEF_IDLE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPar   = 2'd2
    } state_e;

    // Bits needed to hold WIDTH-1 (at least one).
    function automatic int unsigned clog2(input int unsigned width);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < width) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bit_serializer_cnt.sv
// Loadable down-counter with terminal-count flag; stops at zero.
module bit_serializer_cnt #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end, MSB first, one bit per clock on x.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             busy,
    output logic             sof,
    output logic             word_done
);

    localparam int unsigned CW = clog2(WIDTH);

    state_e           r_state, w_state_d;
    // Holds the bits still to be driven after the one currently on x.
    logic [WIDTH-1:0] r_shift, w_shift_d;
    logic             r_x, w_x_d;
    logic             r_busy, w_busy_d;
    logic             r_sof, w_sof_d;
    logic             r_done, w_done_d;
    logic             w_accept;
    logic             w_cnt_load, w_cnt_en, w_tc;
    logic [CW-1:0]    w_cnt;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             r_par, w_par_d;
`endif

    bit_serializer_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (CW'(WIDTH - 1)),
        .i_en       (w_cnt_en),
        .o_count    (w_cnt),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_d  = r_state;
        w_shift_d  = r_shift;
        w_x_d      = IDLE_LEVEL;
        w_busy_d   = 1'b0;
        w_sof_d    = 1'b0;
        w_done_d   = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        in_ready   = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        w_par_d    = r_par;
`endif

        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
            end
            StShift: begin
                if (!w_tc) begin
                    w_shift_d = {r_shift[WIDTH-2:0], 1'b0};
                    w_x_d     = r_shift[WIDTH-1];
                    w_busy_d  = 1'b1;
                    w_cnt_en  = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                    w_par_d   = r_par ^ r_x;
`else
                    w_done_d  = (w_cnt == CW'(1));
`endif
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    w_par_d   = r_par ^ r_x;
                    w_x_d     = r_par ^ r_x;
                    w_busy_d  = 1'b1;
                    w_done_d  = 1'b1;
                    w_state_d = StPar;
`else
                    in_ready  = 1'b1;
                    w_state_d = StIdle;
`endif
                end
            end
            StPar: begin
                in_ready  = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Accept overrides the idle/end-of-frame defaults so words run gapless.
        w_accept = in_valid & in_ready;
        if (w_accept) begin
            w_state_d  = StShift;
            w_shift_d  = {in_data[WIDTH-2:0], 1'b0};
            w_x_d      = in_data[WIDTH-1];
            w_busy_d   = 1'b1;
            w_sof_d    = 1'b1;
            w_done_d   = 1'b0;
            w_cnt_load = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            w_par_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_x     <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_sof   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_x     <= w_x_d;
            r_busy  <= w_busy_d;
            r_sof   <= w_sof_d;
            r_done  <= w_done_d;
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_d;
        end
    end
`endif

    assign x         = r_x;
    assign busy      = r_busy;
    assign sof       = r_sof;
    assign word_done = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8 and WIDTH=4/IDLE_LEVEL=1 instances).
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [7:0] bits;  // expected x sequence, MSB first
        logic       par;   // expected even-parity bit
    } vec_t;

    typedef struct {
        logic x;
        logic sof;
        logic done;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, x, busy, sof, word_done;
    logic [3:0] in_data4 = 4'h0;
    logic       in_valid4 = 1'b0;
    logic       in_ready4, x4, busy4, sof4, word_done4;

    always #5 clk = ~clk;

    bit_serializer #(
        .WIDTH      (8),
        .IDLE_LEVEL (1'b0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .busy      (busy),
        .sof       (sof),
        .word_done (word_done)
    );

    bit_serializer #(
        .WIDTH      (4),
        .IDLE_LEVEL (1'b1)
    ) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .x         (x4),
        .busy      (busy4),
        .sof       (sof4),
        .word_done (word_done4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_word(input int idx);
        exp_t t;
        for (int i = 7; i >= 0; i--) begin
            t.x    = vecs[idx].bits[i];
            t.sof  = (i == 7);
            t.done = (i == 0) && (PAR_EN == 0);
            sb.push_back(t);
        end
        if (PAR_EN != 0) begin
            t.x    = vecs[idx].par;
            t.sof  = 1'b0;
            t.done = 1'b1;
            sb.push_back(t);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, in_valid still high.
    task automatic send(input int idx, output int waited);
        waited   = 0;
        in_data  = vecs[idx].data;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_in_time", (waited < 200), 1);
        @(posedge clk);
        push_word(idx);
        @(negedge clk);
    endtask

    // Scoreboard monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) begin
                chk("busy_has_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("x", x, e.x);
                    chk("sof", sof, e.sof);
                    chk("word_done", word_done, e.done);
                    chk("in_ready_busy", in_ready, e.done);
                end
            end else begin
                chk("no_gap", (sb.size() == 0), 1);
                chk("idle_x", x, 0);
                chk("idle_sof", sof, 0);
                chk("idle_word_done", word_done, 0);
                chk("idle_in_ready", in_ready, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [4:0] exp4;
        int         f4;

        vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
        vecs[1] = '{8'hF0, 8'b11110000, 1'b0};
        vecs[2] = '{8'h0F, 8'b00001111, 1'b0};
        vecs[3] = '{8'h3C, 8'b00111100, 1'b0};
        vecs[4] = '{8'hFF, 8'b11111111, 1'b0};
        vecs[5] = '{8'h07, 8'b00000111, 1'b1};
        vecs[6] = '{8'h03, 8'b00000011, 1'b0};
        vecs[7] = '{8'h81, 8'b10000001, 1'b0};

        #12;
        chk("rst_x", x, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sof", sof, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_x4", x4, 1);
        chk("rst_in_ready4", in_ready4, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word.
        send(0, n);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back: second accept only on the final cycle of the first frame.
        send(1, n);
        send(2, n);
        chk("b2b_wait", n, 7 + PAR_EN);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // Stall: request raised during bit 3 waits until the final cycle.
        send(0, n);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        send(3, n);
        chk("stall_wait", n, 5 + PAR_EN);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during bit 4.
        send(4, n);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("abort_x", x, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_word_done", word_done, 0);
        chk("abort_sof", sof, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(7, n);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // Parity vectors (plain data frames when parity is not built in).
        send(5, n);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        send(6, n);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=4, IDLE_LEVEL=1 instance.
        exp4 = 5'b10100;
        f4   = 4 + PAR_EN;
        chk("w4_idle_x", x4, 1);
        chk("w4_in_ready", in_ready4, 1);
        in_data4  = 4'b1010;
        in_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        for (int i = 0; i < f4; i++) begin
            chk("w4_x", x4, exp4[4-i]);
            chk("w4_busy", busy4, 1);
            chk("w4_sof", sof4, (i == 0));
            chk("w4_word_done", word_done4, (i == f4 - 1));
            @(negedge clk);
        end
        chk("w4_end_x", x4, 1);
        chk("w4_end_busy", busy4, 0);
        chk("w4_end_word_done", word_done4, 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
